// File: rtl/poly_eval_pipe.sv
// Two-stage pipelined signed polynomial evaluator (Horner form) with valid/ready on both sides.
// Stage 1 forms a*x+b; stage 2 finishes the quadratic step or passes the linear value through.
module poly_eval_pipe #(
    parameter int W  = 4,
    parameter int CW = 8,
    localparam int OW = 3*W + 2
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 mode,
    input  logic signed [W-1:0]  a,
    input  logic signed [W-1:0]  x,
    input  logic signed [W-1:0]  b,
    input  logic signed [W-1:0]  c,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] y,
    output logic [CW-1:0]        count
);

    localparam int PW = 2*W + 1;

    logic                 s1_v_reg;
    logic signed [PW-1:0] p1_reg;
    logic signed [W-1:0]  x1_reg;
    logic signed [W-1:0]  c1_reg;
    logic                 mode1_reg;
    logic                 out_valid_reg;
    logic signed [OW-1:0] y_reg;
    logic [CW-1:0]        count_reg;

    logic s2_adv;
    logic s1_adv;

    assign s2_adv   = !out_valid_reg || out_ready;
    assign s1_adv   = !s1_v_reg || s2_adv;
    assign in_ready = s1_adv;

    // Operands are explicitly sign-extended to the full stage width before any arithmetic.
    logic signed [PW-1:0] a_ext, x_ext, b_ext, p1_next;
    assign a_ext   = {{(PW-W){a[W-1]}}, a};
    assign x_ext   = {{(PW-W){x[W-1]}}, x};
    assign b_ext   = {{(PW-W){b[W-1]}}, b};
    assign p1_next = a_ext * x_ext + b_ext;

    logic signed [OW-1:0] p1_wide, x1_wide, c1_wide, y_quad, y_next;
    assign p1_wide = {{(OW-PW){p1_reg[PW-1]}}, p1_reg};
    assign x1_wide = {{(OW-W){x1_reg[W-1]}}, x1_reg};
    assign c1_wide = {{(OW-W){c1_reg[W-1]}}, c1_reg};
    assign y_quad  = p1_wide * x1_wide + c1_wide;
    assign y_next  = mode1_reg ? y_quad : p1_wide;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_v_reg      <= 1'b0;
            p1_reg        <= '0;
            x1_reg        <= '0;
            c1_reg        <= '0;
            mode1_reg     <= 1'b0;
            out_valid_reg <= 1'b0;
            y_reg         <= '0;
            count_reg     <= '0;
        end else begin
            if (s1_adv) begin
                s1_v_reg <= in_valid;
                if (in_valid) begin
                    p1_reg    <= p1_next;
                    x1_reg    <= x;
                    c1_reg    <= c;
                    mode1_reg <= mode;
                end
            end
            // y only reloads on a real result so a bubble never disturbs the last value.
            if (s2_adv) begin
                out_valid_reg <= s1_v_reg;
                if (s1_v_reg) begin
                    y_reg <= y_next;
                end
            end
            if (out_valid_reg && out_ready) begin
                count_reg <= count_reg + CW'(1);
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign y         = y_reg;
    assign count     = count_reg;

endmodule

// File: tb/tb_poly_eval_pipe.sv
// Bench for poly_eval_pipe: directed and random operand streams with stalls, checked
// against a two-entry in-order result queue that models latency and backpressure.
module tb_poly_eval_pipe;

    localparam int W  = 4;
    localparam int OW = 3*W + 2;

    logic                 CLK = 1'b0;
    logic                 RST_N;
    logic                 in_valid;
    logic                 mode;
    logic signed [W-1:0]  a, x, b, c;
    logic                 out_ready;
    logic                 in_ready, out_valid;
    logic signed [OW-1:0] y;
    logic [7:0]           count;
    logic                 in_ready2, out_valid2;
    logic signed [OW-1:0] y2;
    logic [1:0]           count2;

    always #5 CLK = ~CLK;

    poly_eval_pipe #(.W(W), .CW(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
        .a(a), .x(x), .b(b), .c(c), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .count(count)
    );

    poly_eval_pipe #(.W(W), .CW(2)) dut_cw2 (
        .CLK(CLK), .RST_N(RST_N), .in_valid(in_valid), .in_ready(in_ready2), .mode(mode),
        .a(a), .x(x), .b(b), .c(c), .out_valid(out_valid2), .out_ready(out_ready),
        .y(y2), .count(count2)
    );

    typedef struct {
        logic signed [OW-1:0] val;
        int                   acc_edge;
    } item_t;

    item_t q[$];
    int    edge_n = 0;
    int    cnt    = 0;
    int    checks = 0;
    int    errors = 0;

    function automatic logic signed [OW-1:0] ref_y(input bit md, input int av, input int xv,
                                                   input int bv, input int cv);
        int r;
        r = av * xv + bv;
        if (md) r = r * xv + cv;
        return OW'(r);
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check at the falling edge, then advance the model at the rising edge.
    task automatic step(input bit iv, input bit md, input int av, input int xv, input int bv,
                        input int cv, input bit ordy, output bit acc);
        bit exp_ov, exp_ir, otx;
        logic signed [OW-1:0] obs;
        in_valid  = iv;
        mode      = md;
        a         = av[W-1:0];
        x         = xv[W-1:0];
        b         = bv[W-1:0];
        c         = cv[W-1:0];
        out_ready = ordy;
        @(negedge CLK);
        exp_ov = (q.size() > 0) && (q[0].acc_edge + 2 <= edge_n);
        exp_ir = !(q.size() == 2 && !ordy);
        chk("out_valid", out_valid, exp_ov);
        chk("in_ready", in_ready, exp_ir);
        chk("count", count, cnt % 256);
        chk("count_cw2", count2, cnt % 4);
        if (exp_ov) chk("y", y, q[0].val);
        obs = y;
        acc = iv && exp_ir;
        otx = exp_ov && ordy;
        @(posedge CLK);
        if (otx) begin
            void'(q.pop_front());
            cnt++;
            $display("txn out: y=%0d count=%0d", obs, cnt);
        end
        if (acc) q.push_back('{ref_y(md, av, xv, bv, cv), edge_n});
        edge_n++;
        #1;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge CLK);
        RST_N = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_y", y, '0);
        chk("rst_count", count, '0);
        chk("rst_count_cw2", count2, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        q.delete();
        @(posedge CLK);
        #1;
        chk("rst_hold_in_ready", in_ready, 1'b1);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        edge_n += 2;
        cnt = 0;
        #1;
    endtask

    task automatic drain();
        bit acc;
        for (int i = 0; i < 8 && q.size() > 0; i++) step(0, 0, 0, 0, 0, 0, 1, acc);
    endtask

    initial begin
        bit acc;
        int sent;
        int xs[4] = '{2, 5, -6, 7};
        RST_N = 1'b0;
        in_valid = 1'b0; mode = 1'b0; a = '0; x = '0; b = '0; c = '0; out_ready = 1'b1;
        do_reset();

        // Linear stream a=3, b=-4 at full rate.
        for (int i = 0; i < 4; i++) step(1, 0, 3, xs[i], -4, 0, 1, acc);
        drain();

        // Quadratic points including the extreme operand corners.
        step(1, 1, 3, 2, -4, 1, 1, acc);
        step(1, 1, -8, -8, 7, 7, 1, acc);
        step(1, 1, -8, -8, -8, -8, 1, acc);
        drain();

        // Mixed modes back to back.
        step(1, 0, -7, 5, 3, 6, 1, acc);
        step(1, 1, -7, 5, 3, 6, 1, acc);
        step(1, 0, 7, -8, -1, 2, 1, acc);
        drain();

        // Backpressure: out_ready low for cycles 3..6 of a six-set stream.
        sent = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            step(sent < 6, sent[0], 2, sent - 3, 1, -5, !(cyc >= 3 && cyc <= 6), acc);
            if (acc) sent++;
        end
        drain();

        // Fill both stages, then reset mid-stream.
        for (int i = 0; i < 4 && q.size() < 2; i++) step(1, 1, 5, -3, 2, 4, 0, acc);
        do_reset();
        step(1, 1, 3, 2, -4, 1, 1, acc);
        drain();

        // Random traffic with random stalls; CW=2 instance wraps many times.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                 int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                 int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
                 $urandom_range(0, 3) != 0, acc);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
